mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
- Shares one sequential signed shift-add multiplier core among NREQ requesters.
- Picks a requester round-robin, latches its operands, and pulses start on the core.
- Waits for the core's done, then returns the product tagged with the requester ID through a valid/ready response port.
- Sits between the lab's requester logic and the single multiplier instance; it is the only driver of the core's start and operand inputs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- N, 4, operand width in bits (two's complement); product width is 2N.
- IDW, $clog2(NREQ), requester-ID width (derived, minimum 1).

Ports:
- CLK  in  1  single clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ  in  NREQ  per-requester request level; held high until that requester's GNT bit pulses.
- REQ_PLICAND  in  NREQ*N  packed multiplicands; slice i = [i*N +: N].
- REQ_PLIER  in  NREQ*N  packed multipliers, same packing.
- GNT  out  NREQ  one-hot, one-cycle grant pulse.
- RSP_VALID  out  1  response valid.
- RSP_READY  in  1  response accepted.
- RSP_ID  out  IDW  index of the served requester.
- RSP_PRODUCT  out  2N  signed product.
- M_START  out  1  one-cycle start pulse to the core.
- M_PLICAND  out  N  core multiplicand; held stable from M_START until M_DONE.
- M_PLIER  out  N  core multiplier; same hold rule.
- M_DONE  in  1  core completion pulse.
- M_PRODUCT  in  2N  core product; valid while M_DONE is high.
- BUSY  out  1  high in every state except IDLE.
- STATE  out  2  debug encoding of the current state.

Behaviour:
- Reset:
  - Applies on a rising CLK edge with RESET high, from any state.
  - State becomes IDLE; round-robin pointer becomes 0.
  - GNT, M_START, RSP_VALID and BUSY become 0.
  - RSP_ID, RSP_PRODUCT, M_PLICAND and M_PLIER become 0.
  - Reset mid-operation discards the operation. No GNT is reissued unless REQ is still high. A late M_DONE is ignored.
- States (STATE encoding): IDLE=0, ISSUE=1, WAIT=2, RESP=3.
- IDLE:
  - If REQ != 0, the winner is the first set bit searching upward from the pointer, wrapping at NREQ-1 -> 0.
  - On that edge, latch the winner's operands into M_PLICAND/M_PLIER and its index into RSP_ID, then go to ISSUE.
  - If REQ == 0, stay in IDLE.
- ISSUE:
  - Lasts exactly one cycle: GNT[RSP_ID]=1 and M_START=1.
  - Pointer becomes (RSP_ID+1) mod NREQ; go to WAIT.
- WAIT:
  - On M_DONE=1, register M_PRODUCT into RSP_PRODUCT and go to RESP.
  - M_DONE in any other state is ignored.
- RESP:
  - RSP_VALID=1; RSP_ID and RSP_PRODUCT are held constant.
  - On RSP_VALID&&RSP_READY, go to IDLE.
- Latency: REQ seen -> GNT/M_START takes 1 cycle. M_DONE -> RSP_VALID takes 1 cycle. Minimum back-to-back gap is one IDLE cycle.
- Requests arriving while BUSY wait; no request queueing beyond the REQ levels.
- A REQ bit dropped before its grant is simply not served.
- Simultaneous M_DONE and RESET: RESET wins.
- GNT is never multi-hot. M_START never pulses outside ISSUE.

Optional Feature:
- Macro: MULT_ARB_ZERO_BYPASS_EN.
- Defined: in IDLE, if the winner's PLICAND==0 or PLIER==0, set a bypass flag.
  - ISSUE still pulses GNT and advances the pointer, but M_START stays 0.
  - The next state is RESP with RSP_PRODUCT=0, skipping WAIT and the core.
- Undefined: every request goes through the core, including zero operands.

Decomposition:
- Package mult_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP) with the 2-bit encoding above;
  - MULT_N_DEFAULT=4 and MULT_NREQ_DEFAULT=4;
  - a function for the packed-operand slice index.
- Sub-module rr_picker (parameter NREQ): combinational, takes REQ and pointer, outputs a one-hot winner and its index plus an any-request flag. It is reused by later shared-resource labs.

Test Plan:
- Single request: N=4, REQ=4'b0010, PLICAND[1]=4'b1101 (-3), PLIER[1]=4'b0101 (5), core model 10 cycles.
  - Expect GNT=4'b0010 one cycle after REQ and M_START in the same cycle.
  - Expect RSP_VALID one cycle after M_DONE, with RSP_ID=1 and RSP_PRODUCT=8'hF1 (-15).
- Concurrent requests: REQ=4'b1010 right after reset.
  - Expect grants in the order 1 then 3.
  - Expect responses 2*(-8)=8'hF0 for requester 1 and 7*7=8'h31 for requester 3.
- Fairness: all four REQ held high for 8 transactions.
  - Expect GNT order 0,1,2,3,0,1,2,3 and never two consecutive grants to the same requester.
- Backpressure: hold RSP_READY=0 for 5 cycles in RESP.
  - Expect RSP_VALID, RSP_ID and RSP_PRODUCT stable and no M_START.
  - Expect return to IDLE on the cycle after RSP_READY=1.
- Reset mid-WAIT: assert RESET for 1 cycle, then pulse M_DONE late.
  - Expect all outputs 0, STATE=0, and no RSP_VALID.
  - Expect the next grant to go to the lowest set REQ bit.
- Zero operand: PLIER[2]=0.
  - With MULT_ARB_ZERO_BYPASS_EN: expect GNT, no M_START, and RSP_PRODUCT=0 two cycles after REQ.
  - Without the macro: expect M_START, and RSP_PRODUCT=0 from the core.

Source files
------------

// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: controller state
// encoding, default sizes and the packed-operand slicing helper.
package mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int MULT_N_DEFAULT    = 4;
    localparam int MULT_NREQ_DEFAULT = 4;

    // LSB position of requester idx's operand inside a packed operand bus
    function automatic int slice_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_picker.sv
// Combinational round-robin picker: finds the first asserted request at or
// above the pointer, wrapping from NREQ-1 back to 0. Shared with other
// shared-resource labs, so it carries no knowledge of the multiplier.
module rr_picker
    import mult_arb_pkg::*;
#(
    parameter int NREQ = MULT_NREQ_DEFAULT,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] winner_onehot,
    output logic [IDW-1:0]  winner_idx,
    output logic            any_req
);

    assign any_req = |req;

    // Walk the requesters starting at the pointer and keep the first hit
    always_comb begin
        logic             found;
        logic [IDW-1:0]   cand;
        winner_onehot = '0;
        winner_idx    = '0;
        found         = 1'b0;
        cand          = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (!found && req[cand]) begin
                found               = 1'b1;
                winner_idx          = cand;
                winner_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one sequential signed multiplier core among NREQ requesters.
// A round-robin winner's operands are latched and handed to the core; the
// product comes back tagged with the requester index on a valid/ready port.
// Optional build macro MULT_ARB_ZERO_BYPASS_EN: when a winner has a zero
// operand the core is skipped and a zero product is returned directly.
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ = MULT_NREQ_DEFAULT,
    parameter int N    = MULT_N_DEFAULT,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NREQ-1:0]   REQ,
    input  logic [NREQ*N-1:0] REQ_PLICAND,
    input  logic [NREQ*N-1:0] REQ_PLIER,
    output logic [NREQ-1:0]   GNT,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [IDW-1:0]    RSP_ID,
    output logic [2*N-1:0]    RSP_PRODUCT,
    output logic              M_START,
    output logic [N-1:0]      M_PLICAND,
    output logic [N-1:0]      M_PLIER,
    input  logic              M_DONE,
    input  logic [2*N-1:0]    M_PRODUCT,
    output logic              BUSY,
    output logic [1:0]        STATE
);

`ifdef MULT_ARB_ZERO_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    arb_state_t       state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   ptr_next;
    logic [NREQ-1:0]  win_onehot;
    logic [IDW-1:0]   win_idx;
    logic             any_req;
    logic             win_zero;
    logic             bypass;
    logic [N-1:0]     plicand_arr [NREQ];
    logic [N-1:0]     plier_arr   [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign plicand_arr[i] = REQ_PLICAND[slice_lsb(i, N) +: N];
        assign plier_arr[i]   = REQ_PLIER[slice_lsb(i, N) +: N];
    end

    rr_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_picker (
        .req           (REQ),
        .ptr           (ptr),
        .winner_onehot (win_onehot),
        .winner_idx    (win_idx),
        .any_req       (any_req)
    );

    assign win_zero = BYPASS_EN &&
                      ((plicand_arr[win_idx] == '0) || (plier_arr[win_idx] == '0));
    assign ptr_next = (int'(RSP_ID) == NREQ - 1) ? '0 : RSP_ID + IDW'(1);
    assign BUSY     = (state != IDLE);
    assign STATE    = state;

    // Controller FSM: grant, start the core, wait for done, hold the response
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            ptr         <= '0;
            GNT         <= '0;
            M_START     <= 1'b0;
            RSP_VALID   <= 1'b0;
            RSP_ID      <= '0;
            RSP_PRODUCT <= '0;
            M_PLICAND   <= '0;
            M_PLIER     <= '0;
            bypass      <= 1'b0;
        end else begin
            GNT     <= '0;
            M_START <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        M_PLICAND <= plicand_arr[win_idx];
                        M_PLIER   <= plier_arr[win_idx];
                        RSP_ID    <= win_idx;
                        bypass    <= win_zero;
                        GNT       <= win_onehot;
                        M_START   <= !win_zero;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    ptr <= ptr_next;
                    if (bypass) begin
                        RSP_PRODUCT <= '0;
                        RSP_VALID   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (M_DONE) begin
                        RSP_PRODUCT <= M_PRODUCT;
                        RSP_VALID   <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: a table of directed
// transactions, hand-written fairness and reset-in-WAIT sequences, and
// randomized traffic checked against a round-robin/arithmetic model.
module tb_mult_share_arbiter;

    localparam int NREQ = 4;
    localparam int N    = 4;

`ifdef MULT_ARB_ZERO_BYPASS_EN
    localparam bit TB_BYPASS = 1'b1;
`else
    localparam bit TB_BYPASS = 1'b0;
`endif

    logic              CLK;
    logic              RESET;
    logic [NREQ-1:0]   REQ;
    logic [NREQ*N-1:0] REQ_PLICAND;
    logic [NREQ*N-1:0] REQ_PLIER;
    logic [NREQ-1:0]   GNT;
    logic              RSP_VALID;
    logic              RSP_READY;
    logic [1:0]        RSP_ID;
    logic [2*N-1:0]    RSP_PRODUCT;
    logic              M_START;
    logic [N-1:0]      M_PLICAND;
    logic [N-1:0]      M_PLIER;
    logic              M_DONE;
    logic [2*N-1:0]    M_PRODUCT;
    logic              BUSY;
    logic [1:0]        STATE;

    int vectors     = 0;
    int miscompares = 0;
    int refPtr      = 0;

    typedef struct {
        bit          doReset;
        logic [3:0]  req;
        logic [15:0] pa;
        logic [15:0] pb;
        int          expId;
        logic [7:0]  expProd;
        int          lat;
        int          readyDelay;
    } vec_t;

    vec_t vecs [6];

    mult_share_arbiter #(.NREQ(NREQ), .N(N)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .REQ         (REQ),
        .REQ_PLICAND (REQ_PLICAND),
        .REQ_PLIER   (REQ_PLIER),
        .GNT         (GNT),
        .RSP_VALID   (RSP_VALID),
        .RSP_READY   (RSP_READY),
        .RSP_ID      (RSP_ID),
        .RSP_PRODUCT (RSP_PRODUCT),
        .M_START     (M_START),
        .M_PLICAND   (M_PLICAND),
        .M_PLIER     (M_PLIER),
        .M_DONE      (M_DONE),
        .M_PRODUCT   (M_PRODUCT),
        .BUSY        (BUSY),
        .STATE       (STATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Hard stop in case some sequence never returns
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int sx4(input logic [3:0] v);
        return int'($signed(v));
    endfunction

    // Round-robin rule: first set bit at or above the pointer, wrapping
    function automatic int predict(input logic [3:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] reqV, input logic [15:0] pa,
                                 input logic [15:0] pb);
        REQ         = reqV;
        REQ_PLICAND = pa;
        REQ_PLIER   = pb;
    endtask

    task automatic doReset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        refPtr = 0;
    endtask

    // One full transaction, playing both the requester and the multiplier core
    task automatic doTransaction(input logic [3:0] reqV, input logic [15:0] pa,
                                 input logic [15:0] pb, input int expId,
                                 input logic [7:0] expProd, input int lat,
                                 input int readyDelay, input bit dropOnGrant,
                                 input string tag, output logic [3:0] gntSeen);
        int         waited;
        logic [3:0] expA;
        logic [3:0] expB;
        logic [3:0] opA;
        logic [3:0] opB;
        bit         bypass;
        expA   = pa[expId*N +: N];
        expB   = pb[expId*N +: N];
        bypass = TB_BYPASS && ((expA == 4'd0) || (expB == 4'd0));
        applyStimulus(reqV, pa, pb);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (GNT == '0 && waited < 20);
        gntSeen = GNT;
        checkOutput({tag, " gnt"}, 32'(GNT), 32'(1 << expId));
        if (GNT == '0) return;
        checkOutput({tag, " gnt latency"}, waited, 1);
        checkOutput({tag, " m_start"}, 32'(M_START), 32'(!bypass));
        checkOutput({tag, " m_plicand"}, 32'(M_PLICAND), 32'(expA));
        checkOutput({tag, " m_plier"}, 32'(M_PLIER), 32'(expB));
        checkOutput({tag, " busy"}, 32'(BUSY), 1);
        refPtr = (expId + 1) % NREQ;
        if (dropOnGrant) REQ = REQ & ~GNT;
        opA = M_PLICAND;
        opB = M_PLIER;
        if (!bypass) begin
            tick();
            checkOutput({tag, " wait state"}, 32'(STATE), 2);
            checkOutput({tag, " start one-shot"}, 32'(M_START), 0);
            repeat (lat - 1) tick();
            M_DONE    = 1'b1;
            M_PRODUCT = 8'(sx4(opA) * sx4(opB));
            tick();
            M_DONE    = 1'b0;
            M_PRODUCT = 8'(|$urandom);
        end else begin
            tick();
        end
        checkOutput({tag, " rsp_valid"}, 32'(RSP_VALID), 1);
        checkOutput({tag, " rsp_id"}, 32'(RSP_ID), 32'(expId));
        checkOutput({tag, " rsp_product"}, 32'(RSP_PRODUCT), 32'(expProd));
        for (int i = 0; i < readyDelay; i++) begin
            tick();
            checkOutput({tag, " hold valid"}, 32'(RSP_VALID), 1);
            checkOutput({tag, " hold id"}, 32'(RSP_ID), 32'(expId));
            checkOutput({tag, " hold product"}, 32'(RSP_PRODUCT), 32'(expProd));
            checkOutput({tag, " no start in resp"}, 32'(M_START), 0);
        end
        RSP_READY = 1'b1;
        tick();
        RSP_READY = 1'b0;
        checkOutput({tag, " back to idle"}, 32'(STATE), 0);
        checkOutput({tag, " valid dropped"}, 32'(RSP_VALID), 0);
    endtask

    // Main test sequence
    initial begin
        logic [3:0]  g;
        logic [3:0]  gPrev;
        logic [3:0]  reqV;
        logic [15:0] pa;
        logic [15:0] pb;
        int          expId;
        logic [7:0]  expProd;

        RESET = 1'b1; REQ = '0; REQ_PLICAND = '0; REQ_PLIER = '0;
        RSP_READY = 1'b0; M_DONE = 1'b0; M_PRODUCT = '0;
        tick();
        tick();
        RESET = 1'b0;
        refPtr = 0;
        checkOutput("reset gnt", 32'(GNT), 0);
        checkOutput("reset m_start", 32'(M_START), 0);
        checkOutput("reset rsp_valid", 32'(RSP_VALID), 0);
        checkOutput("reset busy", 32'(BUSY), 0);
        checkOutput("reset state", 32'(STATE), 0);
        checkOutput("reset operands", {M_PLICAND, M_PLIER, RSP_ID, RSP_PRODUCT}, 0);

        vecs[0] = '{1'b1, 4'b0010, 16'h00D0, 16'h0050, 1, 8'hF1, 10, 0};
        vecs[1] = '{1'b1, 4'b1010, 16'h7020, 16'h7080, 1, 8'hF0, 3, 0};
        vecs[2] = '{1'b0, 4'b1000, 16'h7020, 16'h7080, 3, 8'h31, 4, 0};
        vecs[3] = '{1'b0, 4'b0001, 16'h0003, 16'h000E, 0, 8'hFA, 2, 5};
        vecs[4] = '{1'b0, 4'b0100, 16'h0500, 16'h0000, 2, 8'h00, 3, 1};
        vecs[5] = '{1'b0, 4'b0110, 16'h03F0, 16'h02F0, 1, 8'h01, 1, 2};

        $display("[TB] directed table");
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].doReset) doReset();
            doTransaction(vecs[v].req, vecs[v].pa, vecs[v].pb, vecs[v].expId,
                          vecs[v].expProd, vecs[v].lat, vecs[v].readyDelay, 1'b1,
                          $sformatf("vec%0d", v), g);
        end

        $display("[TB] fairness with all requesters held");
        doReset();
        gPrev = '0;
        for (int k = 0; k < 8; k++) begin
            pa = 16'($urandom);
            pb = 16'($urandom);
            expId   = k % NREQ;
            expProd = 8'(sx4(pa[expId*N +: N]) * sx4(pb[expId*N +: N]));
            doTransaction(4'b1111, pa, pb, expId, expProd, 2, 0, 1'b0,
                          $sformatf("fair%0d", k), g);
            if (k > 0) checkOutput($sformatf("fair%0d no repeat", k), 32'(g == gPrev), 0);
            gPrev = g;
        end

        $display("[TB] reset during WAIT");
        applyStimulus(4'b0100, 16'h0300, 16'h0300);
        tick();
        checkOutput("rst-wait gnt", 32'(GNT), 32'b0100);
        REQ = '0;
        tick();
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        refPtr = 0;
        checkOutput("rst-wait state", 32'(STATE), 0);
        checkOutput("rst-wait busy", 32'(BUSY), 0);
        checkOutput("rst-wait outputs", {GNT, M_START, RSP_VALID, M_PLICAND, M_PLIER,
                                         RSP_ID, RSP_PRODUCT}, 0);
        tick();
        M_DONE    = 1'b1;
        M_PRODUCT = 8'h55;
        tick();
        M_DONE = 1'b0;
        checkOutput("late done ignored valid", 32'(RSP_VALID), 0);
        checkOutput("late done ignored state", 32'(STATE), 0);
        doTransaction(4'b1100, 16'h2300, 16'h5300, 2, 8'h09, 2, 0, 1'b1, "post-reset", g);

        $display("[TB] randomized traffic");
        for (int r = 0; r < 24; r++) begin
            reqV    = 4'($urandom_range(1, 15));
            pa      = 16'($urandom);
            pb      = 16'($urandom);
            expId   = predict(reqV, refPtr);
            expProd = 8'(sx4(pa[expId*N +: N]) * sx4(pb[expId*N +: N]));
            doTransaction(reqV, pa, pb, expId, expProd, int'($urandom_range(1, 5)),
                          int'($urandom_range(0, 3)), 1'b1, $sformatf("rand%0d", r), g);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
